multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM driving the 32-bit datapath and ALU (op[1:0]: 00 and, 01 or, 10 arith, 11 slt; op[2]=subtract).
//  It accepts one instruction per handshake, sequences fetch/decode/execute/memory/writeback, and issues ALU op,
//  mux selects and write enables each cycle. It also consumes the ALU zero flag for branches.
// PARAMETERS
//  CNT_W    32   width of retired-instruction counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  ins_valid    in   1      instruction word valid (fetch side)
//  ins          in   32     instruction word; opcode=ins[31:26], funct=ins[5:0]
//  ins_ready    out  1      controller accepts ins this cycle
//  alu_zero     in   1      ALU zero flag (z==0)
//  mem_ack      in   1      data memory completes request this cycle
//  alu_op       out  3      ALU op code
//  alu_src_a    out  1      0=PC, 1=rs
//  alu_src_b    out  2      00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  pc_write     out  1      PC load enable
//  pc_src       out  2      00=ALU result, 01=ALUOut register, 10=jump target
//  reg_write    out  1      register file write enable
//  reg_dst      out  1      0=rt, 1=rd
//  mem_to_reg   out  1      writeback data: 0=ALUOut, 1=memory data
//  mem_req      out  1      data memory request
//  mem_we       out  1      data memory write (valid only with mem_req)
//  illegal      out  1      one-cycle pulse: unsupported instruction
//  retired      out  CNT_W  count of completed legal instructions
// BEHAVIOUR
//  Reset: state S_RST; every output 0, retired=0, IR=0. S_RST -> FETCH unconditionally on the next edge.
//  Outputs are Moore-decoded from state. Exceptions: pc_write in FETCH = ins_valid; pc_write in BRANCH = alu_zero.
//  Unlisted outputs are 0 in every state.
//  FETCH: ins_ready=1, src_a=0, src_b=01, alu_op=010, pc_src=00. On ins_valid the IR latches ins -> DECODE.
//    Otherwise the FSM stays in FETCH and pc_write=0.
//  DECODE: src_a=0, src_b=11, alu_op=010 (branch target into ALUOut). Next state by opcode:
//    000000 R-type -> EXEC_R if funct in {100000 add,100010 sub,100100 and,100101 or,101010 slt}, else ILLEGAL
//    001000 addi -> EXEC_I; 100011 lw -> MEM_ADR; 101011 sw -> MEM_ADR; 000100 beq -> BRANCH;
//    000010 j -> JUMP; any other opcode -> ILLEGAL.
//  EXEC_R: src_a=1, src_b=00, alu_op from funct (add 010, sub 110, and 000, or 001, slt 111) -> WB_R.
//  WB_R: reg_dst=1, reg_write=1 -> FETCH.
//  EXEC_I: src_a=1, src_b=10, alu_op=010 -> WB_I. WB_I: reg_dst=0, reg_write=1 -> FETCH.
//  MEM_ADR: src_a=1, src_b=10, alu_op=010. Goes to MEM_RD (lw) or MEM_WR (sw).
//  MEM_RD: mem_req=1, held until mem_ack; on ack -> MEM_WB. MEM_WB: mem_to_reg=1, reg_dst=0, reg_write=1 -> FETCH.
//  MEM_WR: mem_req=1, mem_we=1, held until mem_ack; on ack -> FETCH.
//    mem_ack outside MEM_RD/MEM_WR is ignored.
//  BRANCH: src_a=1, src_b=00, alu_op=110, pc_src=01, pc_write=alu_zero -> FETCH.
//  JUMP: pc_src=10, pc_write=1 -> FETCH.
//  ILLEGAL: illegal=1 for exactly one cycle -> FETCH. The IR is discarded and retired does not increment.
//  retired increments by 1 on each transition into FETCH from WB_R, WB_I, MEM_WB, MEM_WR, BRANCH or JUMP.
//    It wraps modulo 2^CNT_W.
//  Latency in cycles, counted from the FETCH accept: R/addi 4, sw 4+waits, lw 5+waits, beq 3, j 3, illegal 3.
//  rst_n low in any state (including a memory wait) aborts immediately to S_RST. mem_req drops asynchronously.
//  ins_valid is ignored outside FETCH. ins must be stable only in the accept cycle.
//  Unreachable state encodings -> S_RST on the next edge.
// STRUCTURE
//  Shared package cpu_ctrl_pkg: opcode/funct constants, ALU op codes, src_a/src_b/pc_src encodings, state encoding.
//  One sub-module: alu_op_decode (combinational funct -> alu_op, plus a legal flag), reused by EXEC_R and DECODE.
// TESTING
//  Reset: hold rst_n=0 -> all outputs 0. Release -> 1 cycle S_RST, then ins_ready=1.
//  add (000000/funct 100000) with ins_valid=1 -> pc_write=1 cycle 0; alu_op=010,src_b=00 cycle 2; reg_write=1,reg_dst=1 cycle 3; retired=1.
//  lw with mem_ack delayed 3 cycles -> mem_req=1,mem_we=0 for 4 cycles; MEM_WB mem_to_reg=1, reg_write=1; latency 8.
//  beq: alu_zero=1 -> BRANCH pc_write=1, pc_src=01. Repeat with alu_zero=0 -> pc_write=0. retired +1 both times.
//  Illegal: opcode 111111, and R-type with funct 000111 -> illegal pulse exactly 1 cycle, retired unchanged, back to FETCH.
//  rst_n pulsed low mid MEM_WR wait -> mem_req/mem_we 0 at once; FETCH 1 cycle after release; retired=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, functs, ALU ops, mux selects,
// FSM states and the per-cycle control word.
package cpu_ctrl_pkg;

  localparam int unsigned INS_W    = 32;
  localparam int unsigned OPC_W    = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_RS      = 1'b1;
  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_e;

  // Only the fields the controller decodes are kept from the instruction word.
  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [FUNCT_W-1:0] funct;
  } ir_t;

  typedef struct packed {
    logic                ins_ready;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                pc_write;
    logic                pcw_on_valid;
    logic                pcw_on_zero;
    logic [1:0]          pc_src;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                mem_req;
    logic                mem_we;
    logic                illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Fetch/memory handshake and datapath control bundle between the controller and its environment.
interface multicycle_ctrl_if #(parameter int unsigned CNT_W = 32);
  logic             ins_valid;
  logic [31:0]      ins;
  logic             ins_ready;
  logic             alu_zero;
  logic             mem_ack;
  logic [2:0]       alu_op;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             mem_req;
  logic             mem_we;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output ins_valid, ins, alu_zero, mem_ack,
    input  ins_ready, alu_op, alu_src_a, alu_src_b, pc_write, pc_src,
           reg_write, reg_dst, mem_to_reg, mem_req, mem_we, illegal, retired
  );

  modport slave (
    input  ins_valid, ins, alu_zero, mem_ack,
    output ins_ready, alu_op, alu_src_a, alu_src_b, pc_write, pc_src,
           reg_write, reg_dst, mem_to_reg, mem_req, mem_we, illegal, retired
  );
endinterface

// File: rtl/alu_op_decode.sv
// R-type funct to ALU op mapping, with a flag marking the supported functs.
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALU_OP_W-1:0] alu_op_c,
  output logic                legal_c
);
  always_comb begin
    alu_op_c = ALU_ADD;
    legal_c  = 1'b1;
    unique case (funct)
      FN_ADD:  alu_op_c = ALU_ADD;
      FN_SUB:  alu_op_c = ALU_SUB;
      FN_AND:  alu_op_c = ALU_AND;
      FN_OR:   alu_op_c = ALU_OR;
      FN_SLT:  alu_op_c = ALU_SLT;
      default: legal_c  = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback control with a
// retired-instruction counter. Control outputs are flopped from the next-state decode.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.slave  bus
);
  state_e            state_q, state_d;
  ir_t               ir_q, ir_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [ALU_OP_W-1:0] fn_alu_op_c;
  logic              fn_legal_c;

  alu_op_decode u_alu_op_decode (
    .funct    (ir_q.funct),
    .alu_op_c (fn_alu_op_c),
    .legal_c  (fn_legal_c)
  );

  // Next state and instruction register
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (bus.ins_valid) begin
          ir_d    = '{opcode: bus.ins[31:26], funct: bus.ins[5:0]};
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir_q.opcode)
          OPC_RTYPE:      state_d = fn_legal_c ? S_EXEC_R : S_ILLEGAL;
          OPC_ADDI:       state_d = S_EXEC_I;
          OPC_LW, OPC_SW: state_d = S_MEM_ADR;
          OPC_BEQ:        state_d = S_BRANCH;
          OPC_J:          state_d = S_JUMP;
          default:        state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:  state_d = S_WB_R;
      S_WB_R:    state_d = S_FETCH;
      S_EXEC_I:  state_d = S_WB_I;
      S_WB_I:    state_d = S_FETCH;
      S_MEM_ADR: state_d = (ir_q.opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (bus.mem_ack) state_d = S_MEM_WB;
      S_MEM_WB:  state_d = S_FETCH;
      S_MEM_WR:  if (bus.mem_ack) state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ILLEGAL: begin
        ir_d    = '0;
        state_d = S_FETCH;
      end
      default:   state_d = S_RST;
    endcase
  end

  // Control word for the state being entered, so every output comes straight from a flop
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.ins_ready    = 1'b1;
        ctrl_d.alu_src_a    = SRC_A_PC;
        ctrl_d.alu_src_b    = SRC_B_FOUR;
        ctrl_d.alu_op       = ALU_ADD;
        ctrl_d.pc_src       = PC_SRC_ALU;
        ctrl_d.pcw_on_valid = 1'b1;
      end
      S_DECODE: begin
        ctrl_d.alu_src_a = SRC_A_PC;
        ctrl_d.alu_src_b = SRC_B_IMM_SH2;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl_d.alu_src_a = SRC_A_RS;
        ctrl_d.alu_src_b = SRC_B_RT;
        ctrl_d.alu_op    = fn_alu_op_c;
      end
      S_WB_R: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      S_EXEC_I, S_MEM_ADR: begin
        ctrl_d.alu_src_a = SRC_A_RS;
        ctrl_d.alu_src_b = SRC_B_IMM;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_WB_I:   ctrl_d.reg_write = 1'b1;
      S_MEM_RD: ctrl_d.mem_req   = 1'b1;
      S_MEM_WB: begin
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.mem_req = 1'b1;
        ctrl_d.mem_we  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a   = SRC_A_RS;
        ctrl_d.alu_src_b   = SRC_B_RT;
        ctrl_d.alu_op      = ALU_SUB;
        ctrl_d.pc_src      = PC_SRC_ALUOUT;
        ctrl_d.pcw_on_zero = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_src   = PC_SRC_JUMP;
        ctrl_d.pc_write = 1'b1;
      end
      S_ILLEGAL: ctrl_d.illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (state_d == S_FETCH &&
        state_q inside {S_WB_R, S_WB_I, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP})
      retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      ir_q      <= '0;
      ctrl_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ctrl_q    <= ctrl_d;
      retired_q <= retired_d;
    end
  end

  // pc_write qualifies the flopped enable with the live accept / zero flag
  assign bus.pc_write   = ctrl_q.pc_write
                        | (ctrl_q.pcw_on_valid & bus.ins_valid)
                        | (ctrl_q.pcw_on_zero  & bus.alu_zero);
  assign bus.ins_ready  = ctrl_q.ins_ready;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.pc_src     = ctrl_q.pc_src;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.mem_req    = ctrl_q.mem_req;
  assign bus.mem_we     = ctrl_q.mem_we;
  assign bus.illegal    = ctrl_q.illegal;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand-written reset sequences.
module tb_multicycle_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_retired = '0;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        zero;
    int          ack_cyc;
    int          lat;
    int          pcw;
    int          regw;
    int          regdst;
    int          m2r;
    int          mreq;
    int          mwe;
    int          ill;
    logic [5:0]  c2;     // {alu_op, alu_src_a, alu_src_b} two cycles after accept
    int          ret;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [5:0] fn);
    return {opc, 20'hA5C3B, fn};
  endfunction

  function automatic vec_t mkv(input logic [31:0] ins, input logic zero, input int ack_cyc,
                               input int lat, input int pcw, input int regw, input int regdst,
                               input int m2r, input int mreq, input int mwe, input int ill,
                               input logic [5:0] c2, input int ret);
    vec_t v;
    v.ins = ins; v.zero = zero; v.ack_cyc = ack_cyc; v.lat = lat; v.pcw = pcw;
    v.regw = regw; v.regdst = regdst; v.m2r = m2r; v.mreq = mreq; v.mwe = mwe;
    v.ill = ill; v.c2 = c2; v.ret = ret;
    return v;
  endfunction

  function automatic logic [19:0] all_outs();
    return {bus.ins_ready, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_write, bus.pc_src,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.mem_req, bus.mem_we, bus.illegal};
  endfunction

  // Issue one instruction from FETCH, trace it until ins_ready returns, compare the trace.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0, lat = -1, pcw = 0, regw = 0, regdst = 0, m2r = 0, mreq = 0, mwe = 0, ill = 0;
    logic [5:0] c2 = '0;
    bit done = 1'b0;
    string tag;
    tag = $sformatf("v%0d", idx);
    while (!done && cyc < 40) begin
      @(negedge clk);
      bus.ins_valid = (cyc == 0);
      bus.ins       = (cyc == 0) ? v.ins : 32'hFFFF_FFFF;
      bus.alu_zero  = v.zero;
      bus.mem_ack   = (cyc == v.ack_cyc);
      #1;
      if (cyc > 0 && bus.ins_ready) begin
        done = 1'b1;
        lat  = cyc;
      end else begin
        pcw    += int'(bus.pc_write);
        regw   += int'(bus.reg_write);
        regdst += int'(bus.reg_dst);
        m2r    += int'(bus.mem_to_reg);
        mreq   += int'(bus.mem_req);
        mwe    += int'(bus.mem_we);
        ill    += int'(bus.illegal);
        if (cyc == 2) c2 = {bus.alu_op, bus.alu_src_a, bus.alu_src_b};
      end
      cyc++;
    end
    bus.mem_ack = 1'b0;
    exp_retired += 32'(v.ret);
    chk({tag, " done"},    64'(done),   64'd1);
    chk({tag, " latency"}, 64'(lat),    64'(v.lat));
    chk({tag, " pc_write_cycles"},  64'(pcw),    64'(v.pcw));
    chk({tag, " reg_write_cycles"}, 64'(regw),   64'(v.regw));
    chk({tag, " reg_dst_cycles"},   64'(regdst), 64'(v.regdst));
    chk({tag, " mem_to_reg_cycles"},64'(m2r),    64'(v.m2r));
    chk({tag, " mem_req_cycles"},   64'(mreq),   64'(v.mreq));
    chk({tag, " mem_we_cycles"},    64'(mwe),    64'(v.mwe));
    chk({tag, " illegal_cycles"},   64'(ill),    64'(v.ill));
    chk({tag, " cycle2_alu"},       64'(c2),     64'(v.c2));
    chk({tag, " retired"},          64'(bus.retired), 64'(exp_retired));
  endtask

  initial begin
    //               ins                          z  ack lat pcw rw rd m2r mrq mwe ill c2         ret
    vecs.push_back(mkv(mk(6'b000000, 6'b100000), 1, 1, 4, 1, 1, 1, 0, 0, 0, 0, 6'b010_1_00, 1)); // add
    vecs.push_back(mkv(mk(6'b000000, 6'b100010), 1, 1, 4, 1, 1, 1, 0, 0, 0, 0, 6'b110_1_00, 1)); // sub
    vecs.push_back(mkv(mk(6'b000000, 6'b100100), 1, 1, 4, 1, 1, 1, 0, 0, 0, 0, 6'b000_1_00, 1)); // and
    vecs.push_back(mkv(mk(6'b000000, 6'b100101), 1, 1, 4, 1, 1, 1, 0, 0, 0, 0, 6'b001_1_00, 1)); // or
    vecs.push_back(mkv(mk(6'b000000, 6'b101010), 1, 1, 4, 1, 1, 1, 0, 0, 0, 0, 6'b111_1_00, 1)); // slt
    vecs.push_back(mkv(mk(6'b001000, 6'b000011), 1, 1, 4, 1, 1, 0, 0, 0, 0, 0, 6'b010_1_10, 1)); // addi
    vecs.push_back(mkv(mk(6'b100011, 6'b000000), 1, 6, 8, 1, 1, 0, 1, 4, 0, 0, 6'b010_1_10, 1)); // lw, 3 waits
    vecs.push_back(mkv(mk(6'b100011, 6'b000000), 1, 3, 5, 1, 1, 0, 1, 1, 0, 0, 6'b010_1_10, 1)); // lw, no wait
    vecs.push_back(mkv(mk(6'b101011, 6'b000000), 1, 3, 4, 1, 0, 0, 0, 1, 1, 0, 6'b010_1_10, 1)); // sw, no wait
    vecs.push_back(mkv(mk(6'b101011, 6'b000000), 1, 5, 6, 1, 0, 0, 0, 3, 3, 0, 6'b010_1_10, 1)); // sw, 2 waits
    vecs.push_back(mkv(mk(6'b000100, 6'b000000), 1, 1, 3, 2, 0, 0, 0, 0, 0, 0, 6'b110_1_00, 1)); // beq taken
    vecs.push_back(mkv(mk(6'b000100, 6'b000000), 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 6'b110_1_00, 1)); // beq not taken
    vecs.push_back(mkv(mk(6'b000010, 6'b000000), 1, 1, 3, 2, 0, 0, 0, 0, 0, 0, 6'b000_0_00, 1)); // j
    vecs.push_back(mkv(mk(6'b111111, 6'b100000), 1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 6'b000_0_00, 0)); // bad opcode
    vecs.push_back(mkv(mk(6'b000000, 6'b000111), 1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 6'b000_0_00, 0)); // bad funct

    rst_n = 1'b0;
    bus.ins_valid = 1'b1;
    bus.ins = mk(6'b000000, 6'b100000);
    bus.alu_zero = 1'b1;
    bus.mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset outputs", 64'(all_outs()), 64'd0);
    chk("reset retired", 64'(bus.retired), 64'd0);

    // Release: one cycle in S_RST, then FETCH
    bus.ins_valid = 1'b0;
    bus.mem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("srst outputs", 64'(all_outs()), 64'd0);
    @(negedge clk);
    #1;
    chk("fetch ins_ready", 64'(bus.ins_ready), 64'd1);
    chk("fetch idle pc_write", 64'(bus.pc_write), 64'd0);
    chk("fetch alu", 64'({bus.alu_op, bus.alu_src_a, bus.alu_src_b}), 64'(6'b010_0_01));

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset in the middle of a store's memory wait
    @(negedge clk);
    bus.ins_valid = 1'b1;
    bus.ins = mk(6'b101011, 6'b000000);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    bus.ins_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("sw wait mem_req", 64'({bus.mem_req, bus.mem_we}), 64'(2'b11));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort mem_req/we", 64'({bus.mem_req, bus.mem_we}), 64'd0);
    chk("abort retired", 64'(bus.retired), 64'd0);
    exp_retired = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort srst ins_ready", 64'(bus.ins_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("abort fetch ins_ready", 64'(bus.ins_ready), 64'd1);
    chk("abort fetch retired", 64'(bus.retired), 64'(exp_retired));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
